// File: rtl/gray_fifo_rd_ctrl_pkg.sv
// Shared types and helpers for the Gray-pointer FIFO read controller.
// Pure definitions, no state; the TMR vote helper is combinational.
package gray_fifo_rd_ctrl_pkg;

  localparam int PTR_W  = 4;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  typedef logic [PTR_W-1:0] ptr_t;

  typedef struct packed {
    ptr_t rbin;
    ptr_t rgray;
    logic empty;
    ptr_t words;
    logic ovfl;
    logic gray_err;
  } rd_state_t;

  localparam rd_state_t RD_STATE_RST = '{
    rbin:     '0,
    rgray:    '0,
    empty:    1'b1,
    words:    '0,
    ovfl:     1'b0,
    gray_err: 1'b0
  };

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // True when prev and cur differ in zero or one bit.
  function automatic logic gray_step_ok(input ptr_t prev, input ptr_t cur);
    ptr_t d;
    d = prev ^ cur;
    return (d & (d - 1'b1)) == '0;
  endfunction

  function automatic rd_state_t tmr_vote(input rd_state_t a, input rd_state_t b,
                                         input rd_state_t c);
    return rd_state_t'((a & b) | (a & c) | (b & c));
  endfunction

endpackage

// File: rtl/gray_fifo_rd_ctrl_sync.sv
// Synchronises the write-side Gray pointer into CLK, converts it to binary, flags illegal steps.
// Latency SYNC_STAGES cycles to wbin; no backpressure, samples every edge.
module gray_ptr_sync
  import gray_fifo_rd_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  ptr_t wptr_gray,
  output ptr_t wbin,
  output logic gray_err_pulse
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("gray_ptr_sync: SYNC_STAGES must be in 2..4");
  end

  ptr_t sync_q [SYNC_STAGES];
  ptr_t wsync;
  ptr_t wsync_prev;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      wsync_prev <= '0;
    end else begin
      sync_q[0] <= wptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      wsync_prev <= wsync;
    end
  end

  assign wsync          = sync_q[SYNC_STAGES-1];
  assign wbin           = gray2bin(wsync);
  assign gray_err_pulse = ~gray_step_ok(wsync_prev, wsync);

endmodule

// File: rtl/gray_fifo_rd_ctrl.sv
// Read-side pointer/status controller for an 8-deep dual-clock FIFO, optional TMR on state.
// Read accepted combinationally (RD_ACK); status lags writes by SYNC_STAGES+1 edges; reads stall on EMPTY.
module gray_fifo_rd_ctrl
  import gray_fifo_rd_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TMR         = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [PTR_W-1:0]  WPTR_GRAY,
  input  logic              RE,
  output logic              RD_ACK,
  output logic [ADDR_W-1:0] RADDR,
  output logic [PTR_W-1:0]  RPTR_GRAY,
  output logic              EMPTY,
  output logic [PTR_W-1:0]  WORDS,
  output logic              OVFL,
  output logic              GRAY_ERR,
  input  logic              CLR_ERR
);

  ptr_t      wbin;
  logic      gray_err_pulse;
  ptr_t      rnext;
  ptr_t      diff;
  rd_state_t st_d;
  rd_state_t st_v;

  gray_ptr_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .wptr_gray      (WPTR_GRAY),
    .wbin           (wbin),
    .gray_err_pulse (gray_err_pulse)
  );

  assign RD_ACK = RE & ~st_v.empty;

  // Next state is always built from the voted value so a single upset copy is overwritten.
  always_comb begin
    rnext          = st_v.rbin + {{(PTR_W-1){1'b0}}, RD_ACK};
    diff           = wbin - rnext;
    st_d           = st_v;
    st_d.rbin      = rnext;
    st_d.rgray     = bin2gray(rnext);
    st_d.empty     = (diff == '0);
    st_d.words     = (diff > ptr_t'(DEPTH)) ? ptr_t'(DEPTH) : diff;
    st_d.ovfl      = (diff > ptr_t'(DEPTH)) | (st_v.ovfl & ~CLR_ERR);
    st_d.gray_err  = gray_err_pulse | (st_v.gray_err & ~CLR_ERR);
  end

  if (TMR != 0) begin : g_tmr
    rd_state_t st_q0;
    rd_state_t st_q1;
    rd_state_t st_q2;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        st_q0 <= RD_STATE_RST;
        st_q1 <= RD_STATE_RST;
        st_q2 <= RD_STATE_RST;
      end else begin
        st_q0 <= st_d;
        st_q1 <= st_d;
        st_q2 <= st_d;
      end
    end

    assign st_v = tmr_vote(st_q0, st_q1, st_q2);
  end else begin : g_single
    rd_state_t st_q;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        st_q <= RD_STATE_RST;
      end else begin
        st_q <= st_d;
      end
    end

    assign st_v = st_q;
  end

  assign RADDR     = st_v.rbin[ADDR_W-1:0];
  assign RPTR_GRAY = st_v.rgray;
  assign EMPTY     = st_v.empty;
  assign WORDS     = st_v.words;
  assign OVFL      = st_v.ovfl;
  assign GRAY_ERR  = st_v.gray_err;

endmodule

// File: tb/tb_gray_fifo_rd_ctrl.sv
// Directed bench for gray_fifo_rd_ctrl (SYNC_STAGES=2, TMR=1) with hand-computed expectations.
module tb_gray_fifo_rd_ctrl;
  import gray_fifo_rd_ctrl_pkg::*;

  logic       CLK;
  logic       RST_N;
  logic [3:0] WPTR_GRAY;
  logic       RE;
  logic       RD_ACK;
  logic [2:0] RADDR;
  logic [3:0] RPTR_GRAY;
  logic       EMPTY;
  logic [3:0] WORDS;
  logic       OVFL;
  logic       GRAY_ERR;
  logic       CLR_ERR;

  int err_cnt = 0;
  int chk_cnt = 0;
  int wp;
  int rp;
  rd_state_t bad;

  // Reflected Gray codes for 0..15.
  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_fifo_rd_ctrl #(
    .SYNC_STAGES (2),
    .TMR         (1)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .WPTR_GRAY (WPTR_GRAY),
    .RE        (RE),
    .RD_ACK    (RD_ACK),
    .RADDR     (RADDR),
    .RPTR_GRAY (RPTR_GRAY),
    .EMPTY     (EMPTY),
    .WORDS     (WORDS),
    .OVFL      (OVFL),
    .GRAY_ERR  (GRAY_ERR),
    .CLR_ERR   (CLR_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, 32'(EMPTY), 1);
    check({tag, "_words"}, 32'(WORDS), 0);
    check({tag, "_raddr"}, 32'(RADDR), 0);
    check({tag, "_rgray"}, 32'(RPTR_GRAY), 0);
    check({tag, "_ovfl"},  32'(OVFL), 0);
    check({tag, "_gerr"},  32'(GRAY_ERR), 0);
    check({tag, "_ack"},   32'(RD_ACK), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST_N     = 1'b0;
    WPTR_GRAY = 4'h0;
    RE        = 1'b0;
    CLR_ERR   = 1'b0;
    cyc(2);
    RE = 1'b1;
    #1;
    check_reset_outputs("rst");
    RE    = 1'b0;
    RST_N = 1'b1;
    cyc(2);

    // First word: visible at the third edge after the change, not the second.
    WPTR_GRAY = gray_tab[1];
    cyc(2);
    check("first_empty_edge2", 32'(EMPTY), 1);
    cyc(1);
    check("first_empty", 32'(EMPTY), 0);
    check("first_words", 32'(WORDS), 1);
    RE = 1'b1;
    #1;
    check("first_ack", 32'(RD_ACK), 1);
    check("first_raddr", 32'(RADDR), 0);
    cyc(1);
    check("post_raddr", 32'(RADDR), 1);
    check("post_rgray", 32'(RPTR_GRAY), 1);
    check("post_empty", 32'(EMPTY), 1);
    check("post_ack", 32'(RD_ACK), 0);
    cyc(1);
    check("post_hold_raddr", 32'(RADDR), 1);
    RE = 1'b0;

    // Mid-stream asynchronous reset with five words queued.
    WPTR_GRAY = gray_tab[6];
    cyc(3);
    check("mid_words", 32'(WORDS), 5);
    RST_N     = 1'b0;
    WPTR_GRAY = 4'h0;
    #1;
    check_reset_outputs("mid_rst");
    cyc(2);
    RST_N = 1'b1;
    cyc(2);

    // Fill to eight, then one more to overflow.
    for (int k = 1; k <= 8; k++) begin
      WPTR_GRAY = gray_tab[k];
      cyc(1);
    end
    cyc(2);
    check("fill_words", 32'(WORDS), 8);
    check("fill_empty", 32'(EMPTY), 0);
    check("fill_ovfl", 32'(OVFL), 0);
    check("fill_gerr", 32'(GRAY_ERR), 0);
    WPTR_GRAY = gray_tab[9];
    cyc(3);
    check("ovfl_set", 32'(OVFL), 1);
    check("ovfl_words_clamp", 32'(WORDS), 8);
    CLR_ERR = 1'b1;
    cyc(1);
    CLR_ERR = 1'b0;
    check("ovfl_set_wins", 32'(OVFL), 1);
    RE = 1'b1;
    cyc(2);
    RE = 1'b0;
    check("ovfl_drain_words", 32'(WORDS), 7);
    check("ovfl_sticky", 32'(OVFL), 1);
    check("ovfl_drain_raddr", 32'(RADDR), 2);
    CLR_ERR = 1'b1;
    cyc(1);
    CLR_ERR = 1'b0;
    check("ovfl_cleared", 32'(OVFL), 0);

    // Interleaved writes/reads across both pointer wraps; read lands with the synced write.
    wp = 9;
    rp = 2;
    for (int k = 0; k < 20; k++) begin
      wp = (wp + 1) % 16;
      WPTR_GRAY = gray_tab[wp];
      cyc(2);
      check("wrap_pre_words", 32'(WORDS), 7);
      RE = 1'b1;
      #1;
      check("wrap_ack", 32'(RD_ACK), 1);
      check("wrap_raddr", 32'(RADDR), 32'(rp % 8));
      cyc(1);
      RE = 1'b0;
      rp = (rp + 1) % 16;
      check("wrap_words", 32'(WORDS), 7);
      check("wrap_rgray", 32'(RPTR_GRAY), 32'(gray_tab[rp]));
      check("wrap_gerr", 32'(GRAY_ERR), 0);
      check("wrap_ovfl", 32'(OVFL), 0);
    end

    // Two-bit jump on the write pointer.
    RST_N     = 1'b0;
    WPTR_GRAY = 4'h0;
    cyc(2);
    RST_N = 1'b1;
    cyc(2);
    WPTR_GRAY = 4'b0011;
    cyc(2);
    check("gerr_edge2", 32'(GRAY_ERR), 0);
    cyc(1);
    check("gerr_set", 32'(GRAY_ERR), 1);
    check("gerr_words", 32'(WORDS), 2);
    cyc(2);
    check("gerr_sticky", 32'(GRAY_ERR), 1);
    CLR_ERR = 1'b1;
    cyc(1);
    CLR_ERR = 1'b0;
    check("gerr_cleared", 32'(GRAY_ERR), 0);

    // Drain, then keep requesting while empty.
    RE = 1'b1;
    cyc(2);
    #1;
    check("udf_ack", 32'(RD_ACK), 0);
    check("udf_empty", 32'(EMPTY), 1);
    check("udf_raddr", 32'(RADDR), 2);
    cyc(2);
    check("udf_hold_raddr", 32'(RADDR), 2);
    check("udf_hold_rgray", 32'(RPTR_GRAY), 3);
    check("udf_hold_words", 32'(WORDS), 0);
    check("udf_hold_ovfl", 32'(OVFL), 0);
    RE = 1'b0;

    // Corrupt one copy of the triplicated state.
    bad      = dut.g_tmr.st_q1;
    bad.rbin = 4'd9;
    force dut.g_tmr.st_q1 = bad;
    #1;
    check("tmr_raddr", 32'(RADDR), 2);
    check("tmr_rgray", 32'(RPTR_GRAY), 3);
    check("tmr_empty", 32'(EMPTY), 1);
    release dut.g_tmr.st_q1;
    cyc(1);
    check("tmr_restore", 32'(dut.g_tmr.st_q1.rbin), 2);
    check("tmr_raddr_after", 32'(RADDR), 2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
